// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback/memory controller.
package wb_pkg;

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WB       = 2'd2
  } wb_state_t;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

endpackage

// File: rtl/wb_controller_if.sv
// Decode/memory/register-file signal bundle seen by the writeback controller.
interface wb_controller_if;
  import wb_pkg::*;

  logic              instr_valid;
  logic              is_load;
  logic              is_store;
  logic              is_jump;
  logic              reg_write;
  logic [RD_W-1:0]   rd;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic [1:0]        sel_dm;
  logic              rf_we;
  logic [RD_W-1:0]   rf_waddr;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              mem_err;

  modport master (
    input  instr_valid, is_load, is_store, is_jump, reg_write, rd,
           dmem_ack, dmem_rdata,
    output sel_dm, rf_we, rf_waddr, dmem_req, dmem_we, load_data,
           stall, mem_err
  );

  modport slave (
    output instr_valid, is_load, is_store, is_jump, reg_write, rd,
           dmem_ack, dmem_rdata,
    input  sel_dm, rf_we, rf_waddr, dmem_req, dmem_we, load_data,
           stall, mem_err
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory access; saturates at TIMEOUT-1.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_controller.sv
// Writeback/memory sequencing controller: single-cycle ALU/jump writes,
// multi-cycle load/store handshake with timeout abort.
module wb_controller
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  wb_controller_if.master  bus
);

  wb_state_t         state;
  wb_state_t         state_next;
  logic [RD_W-1:0]   rd_q;
  logic              op_load;
  logic [DATA_W-1:0] load_data_q;
  logic              mem_err_q;
  logic              expired;
  logic              start_mem;

  logic [1:0]        sel_dm;
  logic              rf_we;
  logic [RD_W-1:0]   rf_waddr;
  logic              dmem_req;
  logic              dmem_we;
  logic              stall;

  assign start_mem = bus.instr_valid && (bus.is_load || bus.is_store);

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_MEM_WAIT),
    .enable  (state == ST_MEM_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Ack on the final wait cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start_mem) state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (bus.dmem_ack)  state_next = op_load ? ST_WB : ST_IDLE;
        else if (expired)  state_next = ST_IDLE;
      end
      ST_WB:       state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= '0;
      op_load     <= 1'b0;
      load_data_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_err_q <= (state == ST_MEM_WAIT) && !bus.dmem_ack && expired;
      if (state == ST_IDLE && start_mem) begin
        rd_q    <= bus.rd;
        op_load <= bus.is_load;
      end
      if (state == ST_MEM_WAIT && bus.dmem_ack && op_load) begin
        load_data_q <= bus.dmem_rdata;
      end
    end
  end

  // Outputs are quiet while reset is held so an abandoned access never writes.
  always_comb begin
    sel_dm   = SEL_ALU;
    rf_we    = 1'b0;
    rf_waddr = '0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    stall    = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (start_mem) begin
            stall = 1'b1;
          end else if (bus.instr_valid && bus.reg_write && bus.rd != '0) begin
            rf_we    = 1'b1;
            rf_waddr = bus.rd;
            sel_dm   = bus.is_jump ? SEL_PC4 : SEL_ALU;
          end
        end
        ST_MEM_WAIT: begin
          dmem_req = 1'b1;
          dmem_we  = !op_load;
          stall    = 1'b1;
        end
        ST_WB: begin
          if (rd_q != '0) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            sel_dm   = SEL_MEM;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sel_dm    = sel_dm;
  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.stall     = stall;
  assign bus.load_data = load_data_q;
  assign bus.mem_err   = mem_err_q;

endmodule
